// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: write-back port arbiter between functional-unit results
// and the scoreboard.
//
// Each requester owns a one-entry result buffer. Buffered results compete
// for the single write-back port; a grant stays locked while the scoreboard
// stalls. Write-back payload is driven from buffer state only, so results
// appear one cycle after they are accepted.
//
// Configuration macro:
//   WB_ARB_FIXED_PRIO_EN  defined   -> fixed priority (lowest index wins), no rr_ptr
//                         undefined -> round-robin from rr_ptr (default)
//
// Ports:
//   clk_i           clock, all state on rising edge
//   rst_ni          asynchronous active-low reset
//   flush_i         discard all buffered results
//   req_valid_i     per-requester result valid
//   req_ready_o     per-requester accept
//   req_trans_id_i  per-requester scoreboard tag
//   req_data_i      per-requester result value
//   req_ex_i        per-requester exception (cause/tval/valid)
//   wb_valid_o      write-back valid
//   wb_ready_i      scoreboard accepts write-back
//   wb_trans_id_o   granted tag
//   wb_data_o       granted result
//   wb_ex_o         granted exception
//   wb_grant_o      one-hot granted requester, zero when idle

package wb_port_arbiter_pkg;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

endpackage

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned NR_REQ        = 4,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NR_REQ-1:0]        req_valid_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i [NR_REQ],
    input  logic [DATA_WIDTH-1:0]    req_data_i     [NR_REQ],
    input  exception_t               req_ex_i       [NR_REQ],
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    output exception_t               wb_ex_o,
    output logic [NR_REQ-1:0]        wb_grant_o
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    // Per-requester result buffers
    logic [NR_REQ-1:0]        buf_valid_q;
    logic [TRANS_ID_BITS-1:0] buf_trans_id_q [NR_REQ];
    logic [DATA_WIDTH-1:0]    buf_data_q     [NR_REQ];
    exception_t               buf_ex_q       [NR_REQ];

    // Grant lock: holds the granted index while the scoreboard stalls
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;

    logic [IDX_W-1:0]  arb_idx_c;
    logic [IDX_W-1:0]  cand_c;
    logic [IDX_W-1:0]  grant_idx_c;
    logic              pop_c;
    logic [NR_REQ-1:0] accept_c;

`ifdef WB_ARB_FIXED_PRIO_EN

    // Fixed priority: lowest valid index wins (scan downward, last hit kept)
    always_comb begin
        arb_idx_c = '0;
        cand_c    = '0;
        for (int i = int'(NR_REQ) - 1; i >= 0; i--) begin
            cand_c = IDX_W'(i);
            if (buf_valid_q[cand_c]) begin
                arb_idx_c = cand_c;
            end
        end
    end

`else

    logic [IDX_W-1:0] rr_ptr_q;

    // Round-robin: first valid buffer at or above rr_ptr, modulo NR_REQ
    always_comb begin
        arb_idx_c = '0;
        cand_c    = '0;
        for (int i = int'(NR_REQ) - 1; i >= 0; i--) begin
            cand_c = IDX_W'((int'(rr_ptr_q) + i) % int'(NR_REQ));
            if (buf_valid_q[cand_c]) begin
                arb_idx_c = cand_c;
            end
        end
    end

    // Pointer moves past the delivered requester; a flush leaves it alone
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (pop_c && !flush_i) begin
            rr_ptr_q <= (grant_idx_c == IDX_W'(NR_REQ - 1)) ? '0
                                                             : grant_idx_c + IDX_W'(1);
        end
    end

`endif

    // Write-back side, driven from state only
    always_comb begin
        grant_idx_c   = lock_q ? lock_idx_q : arb_idx_c;
        wb_valid_o    = |buf_valid_q;
        wb_grant_o    = wb_valid_o ? (NR_REQ'(1) << grant_idx_c) : '0;
        wb_trans_id_o = buf_trans_id_q[grant_idx_c];
        wb_data_o     = buf_data_q[grant_idx_c];
        wb_ex_o       = buf_ex_q[grant_idx_c];
        pop_c         = wb_valid_o & wb_ready_i;
    end

    // A buffer accepts when empty or when it is being drained this cycle
    always_comb begin
        req_ready_o = {NR_REQ{~flush_i}} & (~buf_valid_q | (wb_grant_o & {NR_REQ{wb_ready_i}}));
        accept_c    = req_valid_i & req_ready_o;
    end

    // Buffer storage; an accept on the popped index keeps it valid with new data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= '0;
            for (int i = 0; i < int'(NR_REQ); i++) begin
                buf_trans_id_q[i] <= '0;
                buf_data_q[i]     <= '0;
                buf_ex_q[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NR_REQ); i++) begin
                if (accept_c[i]) begin
                    buf_valid_q[i]    <= 1'b1;
                    buf_trans_id_q[i] <= req_trans_id_i[i];
                    buf_data_q[i]     <= req_data_i[i];
                    buf_ex_q[i]       <= req_ex_i[i];
                end else if (flush_i || (pop_c && (grant_idx_c == IDX_W'(i)))) begin
                    buf_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Lock the grant across scoreboard stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= wb_valid_o & ~wb_ready_i & ~flush_i;
            lock_idx_q <= grant_idx_c;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int TW = 3;
    localparam logic [63:0] LD_ACCESS_FAULT = 64'd5;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic [N-1:0]  req_valid_i;
    logic [N-1:0]  req_ready_o;
    logic [TW-1:0] req_trans_id_i [N];
    logic [DW-1:0] req_data_i     [N];
    exception_t    req_ex_i       [N];
    logic          wb_valid_o;
    logic          wb_ready_i;
    logic [TW-1:0] wb_trans_id_o;
    logic [DW-1:0] wb_data_o;
    exception_t    wb_ex_o;
    logic [N-1:0]  wb_grant_o;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.NR_REQ(N), .DATA_WIDTH(DW), .TRANS_ID_BITS(TW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_trans_id_i (req_trans_id_i),
        .req_data_i     (req_data_i),
        .req_ex_i       (req_ex_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_data_o      (wb_data_o),
        .wb_ex_o        (wb_ex_o),
        .wb_grant_o     (wb_grant_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a bag of per-requester slots plus arbitration rules
    bit            m_v    [N];
    logic [TW-1:0] m_tid  [N];
    logic [DW-1:0] m_data [N];
    exception_t    m_ex   [N];
    int            m_rr;
    bit            m_lock;
    int            m_lidx;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0; m_tid[i] = '0; m_data[i] = '0; m_ex[i] = '0;
        end
        m_rr = 0; m_lock = 1'b0; m_lidx = 0;
    endfunction

    // Index that should own the write-back port, -1 when nothing is buffered
    function automatic int m_pick();
        int k;
        if (m_lock) return m_lidx;
        for (int off = 0; off < N; off++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            k = off;
`else
            k = (m_rr + off) % N;
`endif
            if (m_v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        int g;
        g = m_pick();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        g = m_pick();
        for (int i = 0; i < N; i++)
            r[i] = !flush_i && (!m_v[i] || (g == i && wb_ready_i));
        return r;
    endfunction

    // Apply one clock edge worth of behaviour using the current inputs
    function automatic void m_advance();
        int g;
        logic [N-1:0] r;
        g = m_pick();
        r = m_ready();
        if (flush_i) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_lock = 1'b0;
            return;
        end
        if (g >= 0 && wb_ready_i) begin
            m_v[g] = 1'b0;
            m_rr   = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid_i[i] && r[i]) begin
                m_v[i] = 1'b1; m_tid[i] = req_trans_id_i[i];
                m_data[i] = req_data_i[i]; m_ex[i] = req_ex_i[i];
            end
        end
        m_lock = (g >= 0) && !wb_ready_i;
        if (m_lock) m_lidx = g;
    endfunction

    task automatic idle_inputs();
        flush_i = 1'b0; req_valid_i = '0; wb_ready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_trans_id_i[i] = '0; req_data_i[i] = '0; req_ex_i[i] = '0;
        end
    endtask

    task automatic adv();
        m_advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        m_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        adv();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        m_reset();
        #2;
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", wb_valid_o); end
        checks++; if (wb_grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", wb_grant_o); end
        checks++; if (req_ready_o !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b exp 1111", req_ready_o); end
        checks++; if (wb_trans_id_o !== '0 || wb_data_o !== '0 || wb_ex_o !== '0) begin
            errors++; $display("FAIL reset_payload got tid=%h data=%h ex=%h exp zero", wb_trans_id_o, wb_data_o, wb_ex_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        adv();
    endtask

    task automatic test_single();
        req_valid_i = 4'b0001; req_trans_id_i[0] = 3'd3; req_data_i[0] = 64'hDEAD; wb_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", wb_valid_o); end
        checks++; if (req_ready_o[0] !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", req_ready_o[0]); end
        adv();
        req_valid_i = '0;
        @(negedge clk_i);
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", wb_valid_o); end
        checks++; if (wb_trans_id_o !== 3'd3) begin errors++; $display("FAIL single_tid got %0d exp 3", wb_trans_id_o); end
        checks++; if (wb_data_o !== 64'hDEAD) begin errors++; $display("FAIL single_data got %h exp dead", wb_data_o); end
        checks++; if (wb_grant_o !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", wb_grant_o); end
        adv();
        @(negedge clk_i);
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", wb_valid_o); end
        adv();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        int exp_i;
        do_reset();
        req_valid_i = '1; wb_ready_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_trans_id_i[i] = TW'(i); req_data_i[i] = 64'(100 + i);
        end
        @(negedge clk_i);
        adv();
        for (int c = 0; c < 5; c++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            exp_i = 0;
`else
            exp_i = c % N;
`endif
            exp_g = N'(1) << exp_i;
            @(negedge clk_i);
            checks++; if (wb_valid_o !== 1'b1 || wb_grant_o !== exp_g) begin
                errors++; $display("FAIL rr_grant cycle %0d got v=%b g=%b exp v=1 g=%b", c, wb_valid_o, wb_grant_o, exp_g);
            end
            checks++; if (wb_trans_id_o !== TW'(exp_i)) begin
                errors++; $display("FAIL rr_tid cycle %0d got %0d exp %0d", c, wb_trans_id_o, exp_i);
            end
            adv();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        req_valid_i = 4'b0100; req_trans_id_i[2] = 3'd5; req_data_i[2] = 64'h2222; wb_ready_i = 1'b0;
        @(negedge clk_i);
        adv();
        req_valid_i = 4'b0001; req_trans_id_i[0] = 3'd1; req_data_i[0] = 64'h1111;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) req_valid_i = '0;
            if (c == 4) wb_ready_i = 1'b1;
            @(negedge clk_i);
            checks++; if (wb_grant_o !== 4'b0100) begin errors++; $display("FAIL lock_grant cycle %0d got %b exp 0100", c, wb_grant_o); end
            checks++; if (wb_trans_id_o !== 3'd5 || wb_data_o !== 64'h2222) begin
                errors++; $display("FAIL lock_payload cycle %0d got tid=%0d data=%h exp 5/2222", c, wb_trans_id_o, wb_data_o);
            end
            adv();
        end
        wb_ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (wb_grant_o !== 4'b0001) begin errors++; $display("FAIL lock_next_grant got %b exp 0001", wb_grant_o); end
        checks++; if (wb_data_o !== 64'h1111) begin errors++; $display("FAIL lock_next_data got %h exp 1111", wb_data_o); end
        adv();
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        req_valid_i = 4'b1010; req_trans_id_i[1] = 3'd2; req_trans_id_i[3] = 3'd6; wb_ready_i = 1'b0;
        @(negedge clk_i);
        adv();
        flush_i = 1'b1; req_valid_i = 4'b0001; req_trans_id_i[0] = 3'd7;
        @(negedge clk_i);
        checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b exp 0000", req_ready_o); end
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b exp 1", wb_valid_o); end
        adv();
        flush_i = 1'b0; req_valid_i = '0;
        @(negedge clk_i);
        checks++; if (wb_valid_o !== 1'b0 || wb_grant_o !== 4'b0000) begin
            errors++; $display("FAIL flush_after got v=%b g=%b exp v=0 g=0000", wb_valid_o, wb_grant_o);
        end
        checks++; if (req_ready_o !== 4'b1111) begin errors++; $display("FAIL flush_empty got %b exp 1111", req_ready_o); end
        adv();
        idle_inputs();
    endtask

    task automatic test_exception();
        exception_t e;
        do_reset();
        e.cause = LD_ACCESS_FAULT; e.tval = 64'h8000_0000; e.valid = 1'b1;
        req_valid_i = 4'b0010; req_trans_id_i[1] = 3'd4; req_data_i[1] = 64'h0; req_ex_i[1] = e; wb_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL exc_latency got %b exp 0", wb_valid_o); end
        adv();
        req_valid_i = '0; req_ex_i[1] = '0;
        @(negedge clk_i);
        checks++; if (wb_ex_o !== e) begin errors++; $display("FAIL exc_payload got %h exp %h", wb_ex_o, e); end
        checks++; if (wb_grant_o !== 4'b0010 || wb_trans_id_o !== 3'd4) begin
            errors++; $display("FAIL exc_grant got g=%b tid=%0d exp 0010/4", wb_grant_o, wb_trans_id_o);
        end
        adv();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid_i = 4'b0111; wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) req_trans_id_i[i] = TW'(i + 1);
        @(negedge clk_i);
        adv();
        req_valid_i = '0;
        @(negedge clk_i);
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", wb_valid_o); end
        #2 rst_ni = 1'b0;
        m_reset();
        #1;
        checks++; if (wb_valid_o !== 1'b0 || wb_grant_o !== 4'b0000) begin
            errors++; $display("FAIL arst_immediate got v=%b g=%b exp v=0 g=0000", wb_valid_o, wb_grant_o);
        end
        checks++; if (req_ready_o !== 4'b1111) begin errors++; $display("FAIL arst_ready got %b exp 1111", req_ready_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1; wb_ready_i = 1'b1;
        adv();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL arst_no_wb cycle %0d got %b exp 0", c, wb_valid_o); end
            adv();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] exp_r;
        exception_t e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid_i = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                req_trans_id_i[i] = TW'($urandom_range(0, 7));
                req_data_i[i]     = {$urandom, $urandom};
                e.cause = {32'h0, $urandom}; e.tval = {$urandom, $urandom}; e.valid = 1'($urandom_range(0, 1));
                req_ex_i[i] = e;
            end
            wb_ready_i = ($urandom_range(0, 3) != 0);
            flush_i    = ($urandom_range(0, 19) == 0);
            @(negedge clk_i);
            g = m_pick();
            exp_r = m_ready();
            checks++; if (wb_valid_o !== (g >= 0) || wb_grant_o !== m_grant()) begin
                errors++; $display("FAIL rand_grant cycle %0d got v=%b g=%b exp v=%b g=%b", c, wb_valid_o, wb_grant_o, g >= 0, m_grant());
            end
            checks++; if (req_ready_o !== exp_r) begin
                errors++; $display("FAIL rand_ready cycle %0d got %b exp %b", c, req_ready_o, exp_r);
            end
            if (g >= 0) begin
                checks++; if (wb_trans_id_o !== m_tid[g] || wb_data_o !== m_data[g] || wb_ex_o !== m_ex[g]) begin
                    errors++; $display("FAIL rand_payload cycle %0d got tid=%0d data=%h ex=%h exp tid=%0d data=%h ex=%h",
                                       c, wb_trans_id_o, wb_data_o, wb_ex_o, m_tid[g], m_data[g], m_ex[g]);
                end
            end
            adv();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_flush();
        test_exception();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 4 (NR_WB_PORTS), number of functional-unit result requesters.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, result width.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all buffered results.
REQ-006 SHALL have port req_valid_i  input  NR_REQ  per-requester result valid.
REQ-007 SHALL have port req_ready_o  output  NR_REQ  per-requester accept.
REQ-008 SHALL have port req_trans_id_i  input  NR_REQ x TRANS_ID_BITS  scoreboard entry tag.
REQ-009 SHALL have port req_data_i  input  NR_REQ x DATA_WIDTH  result value.
REQ-010 SHALL have port req_ex_i  input  NR_REQ x exception  cause/tval/valid from the functional unit.
REQ-011 SHALL have port wb_valid_o  output  1  write-back valid to scoreboard.
REQ-012 SHALL have port wb_ready_i  input  1  scoreboard accepts write-back.
REQ-013 SHALL have ports wb_trans_id_o / wb_data_o / wb_ex_o  output  TRANS_ID_BITS / DATA_WIDTH / exception  granted payload.
REQ-014 SHALL have port wb_grant_o  output  NR_REQ  one-hot index of granted requester (zero when wb_valid_o=0).

Function
REQ-015 SHALL hold one result buffer per requester (buf_valid, trans_id, data, ex).
REQ-016 SHALL accept on req_valid_i[i] & req_ready_o[i], writing buffer i at the clock edge.
REQ-017 SHALL drive req_ready_o[i] = ~flush_i & (~buf_valid[i] | (wb_grant_o[i] & wb_ready_i)), allowing one accept per cycle per requester.
REQ-018 SHALL drive wb_valid_o = OR of buf_valid; payload outputs = granted buffer contents, combinational from state only (no input-to-payload path).
REQ-019 SHALL pop the granted buffer when wb_valid_o & wb_ready_i; simultaneous pop and accept on the same index leaves the buffer valid with new data.
REQ-020 SHALL have latency of exactly 1 cycle: data accepted in cycle N is visible on wb_* no earlier than N+1.
REQ-021 SHALL select the first valid buffer searching from rr_ptr upward modulo NR_REQ (round-robin).
REQ-022 SHALL set rr_ptr to (granted index + 1) mod NR_REQ on each pop; unchanged otherwise; wraps NR_REQ-1 -> 0.
REQ-023 SHALL lock the grant while wb_valid_o & ~wb_ready_i: grant and payload held stable until pop, even if another buffer becomes valid.
REQ-024 SHALL pass req_ex_i unmodified; an exception result arbitrates identically to a normal result.
REQ-025 SHALL on flush_i clear all buf_valid and the grant lock in the same edge, ignore req_valid_i that cycle and leave rr_ptr unchanged; a pop coincident with flush still counts as delivered.
REQ-026 SHALL, with all buffers empty, drive wb_valid_o=0 and wb_grant_o=0.

Reset
REQ-027 SHALL on rst_ni low immediately clear all buf_valid, grant lock and rr_ptr=0; wb_valid_o=0, wb_grant_o=0, req_ready_o all 1 (flush_i low).
REQ-028 SHALL clear buffer payload fields to zero on reset.
REQ-029 SHALL discard any result held at reset assertion mid-operation; no write-back after release until a new accept.

Configuration
REQ-030 SHALL, with macro WB_ARB_FIXED_PRIO_EN defined, select fixed priority (lowest valid index wins) and omit rr_ptr; grant lock (REQ-023) still applies.
REQ-031 SHALL, without WB_ARB_FIXED_PRIO_EN, use round-robin per REQ-021/022.

Verification
REQ-032 SHALL cover: reset, then req_valid_i=4'b0001 trans_id=3 data=64'hDEAD cycle 0, wb_ready_i=1 -> cycle 1 wb_valid_o=1, wb_trans_id_o=3, wb_data_o=64'hDEAD, wb_grant_o=4'b0001.
REQ-033 SHALL cover: all four requesters valid continuously, wb_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, one write-back per cycle (fixed-priority build: requester 0 every cycle).
REQ-034 SHALL cover: buffer 2 granted, wb_ready_i=0 for 3 cycles, buffer 0 filled meanwhile -> wb_grant_o stays 4'b0100, payload stable; pop on cycle 4, then grant 4'b0001 (round-robin: buffer 3 first if valid).
REQ-035 SHALL cover: buffers 1 and 3 full, flush_i=1 with req_valid_i=4'b0001 -> next cycle wb_valid_o=0, buffer 0 empty, req_ready_o low during flush cycle.
REQ-036 SHALL cover: req_ex_i valid=1 cause=LD_ACCESS_FAULT tval=64'h8000_0000 on requester 1 -> wb_ex_o identical one cycle later.
REQ-037 SHALL cover: rst_ni asserted asynchronously mid-cycle with three buffers full -> wb_valid_o=0 before next clock edge, no write-back after release.
